// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a registered grant index and valid flag.
// A grant is held while its owner keeps requesting, and is preempted after MAX_HOLD cycles under contention.
module rr_arbiter_4 #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] req,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       preempt
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [0:0]       state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       gnt_idx_q, gnt_idx_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             preempt_q, preempt_d;

    logic [3:0] g_mask;
    logic [3:0] others;
    logic [1:0] next_ptr;

    // The lowest rotated offset from p that has a request set wins.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        pick = p;
        for (int i = 3; i >= 0; i--) begin
            idx = p + 2'(i);
            if (r[idx]) pick = idx;
        end
    endfunction

    assign g_mask   = 4'b0001 << gnt_idx_q;
    assign others   = req & ~g_mask;
    assign next_ptr = gnt_idx_q + 2'd1;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        preempt_d   = 1'b0;

        if (state_q == IDLE) begin
            gnt_valid_d = 1'b0;
            if (en && (req != 4'b0000)) begin
                gnt_idx_d   = pick(req, ptr_q);
                gnt_valid_d = 1'b1;
                cnt_d       = CNT_ONE;
                state_d     = GRANT;
            end
        end else begin
            if (!req[gnt_idx_q]) begin
                ptr_d = next_ptr;
                if (en && (req != 4'b0000)) begin
                    gnt_idx_d = pick(req, next_ptr);
                    cnt_d     = CNT_ONE;
                end else begin
                    gnt_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end else if ((cnt_q == HOLD_MAX) && en && (others != 4'b0000)) begin
                // The owner sits last in the rotated order, so it cannot win again here.
                ptr_d     = next_ptr;
                gnt_idx_d = pick(req, next_ptr);
                cnt_d     = CNT_ONE;
                preempt_d = 1'b1;
            end else if (cnt_q != HOLD_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd0;
            cnt_q       <= '0;
            gnt_idx_q   <= 2'd0;
            gnt_valid_q <= 1'b0;
            preempt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            preempt_q   <= preempt_d;
        end
    end

    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4 (MAX_HOLD=4): expected outputs are queued as
// each stimulus step is driven and compared once the following clock edge has settled.
module tb_rr_arbiter_4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] req;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
        logic       pre;
    } exp_t;

    exp_t sb[$];
    int   tests_run = 0;
    int   fails     = 0;

    rr_arbiter_4 #(.MAX_HOLD(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic expect_out(input logic v, input logic [1:0] i, input logic p);
        exp_t e;
        e.valid = v;
        e.idx   = i;
        e.pre   = p;
        sb.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        tests_run++;
        assert (sb.size() != 0) else begin
            fails++;
            $error("[TB] FAIL %s scoreboard: got empty queue want an entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            tests_run += 3;
            assert (gnt_valid === e.valid) else begin
                fails++;
                $error("[TB] FAIL %s valid: got %b want %b", tag, gnt_valid, e.valid);
            end
            assert (gnt_idx === e.idx) else begin
                fails++;
                $error("[TB] FAIL %s idx: got %b want %b", tag, gnt_idx, e.idx);
            end
            assert (preempt === e.pre) else begin
                fails++;
                $error("[TB] FAIL %s preempt: got %b want %b", tag, preempt, e.pre);
            end
        end
    endtask

    task automatic step(input string tag, input logic [3:0] r, input logic e,
                        input logic v, input logic [1:0] i, input logic p);
        req = r;
        en  = e;
        expect_out(v, i, p);
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        req   = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        expect_out(1'b0, 2'd0, 1'b0);
        check_out("reset_hold");
        rst_n = 1'b1;

        step("first_grant",   4'b1111, 1'b1, 1'b1, 2'd0, 1'b0);
        step("idle0",         4'b0000, 1'b1, 1'b0, 2'd0, 1'b0);

        // ptr is 1 here, then 3 after requester 2 releases
        step("single_req2",   4'b0100, 1'b1, 1'b1, 2'd2, 1'b0);
        step("single_drop",   4'b0000, 1'b1, 1'b0, 2'd2, 1'b0);
        step("ptr3_pick3",    4'b1001, 1'b1, 1'b1, 2'd3, 1'b0);
        step("idle1",         4'b0000, 1'b1, 1'b0, 2'd3, 1'b0);

        step("fair_g0",       4'b1111, 1'b1, 1'b1, 2'd0, 1'b0);
        step("fair_h0",       4'b1111, 1'b1, 1'b1, 2'd0, 1'b0);
        step("fair_g1",       4'b1110, 1'b1, 1'b1, 2'd1, 1'b0);
        step("fair_h1",       4'b1111, 1'b1, 1'b1, 2'd1, 1'b0);
        step("fair_g2",       4'b1101, 1'b1, 1'b1, 2'd2, 1'b0);
        step("fair_h2",       4'b1111, 1'b1, 1'b1, 2'd2, 1'b0);
        step("fair_g3",       4'b1011, 1'b1, 1'b1, 2'd3, 1'b0);
        step("fair_h3",       4'b1111, 1'b1, 1'b1, 2'd3, 1'b0);
        step("fair_g0_again", 4'b0111, 1'b1, 1'b1, 2'd0, 1'b0);
        step("idle2",         4'b0000, 1'b1, 1'b0, 2'd0, 1'b0);

        step("pre_c1",        4'b0001, 1'b1, 1'b1, 2'd0, 1'b0);
        step("pre_c2",        4'b0101, 1'b1, 1'b1, 2'd0, 1'b0);
        step("pre_c3",        4'b0101, 1'b1, 1'b1, 2'd0, 1'b0);
        step("pre_c4",        4'b0101, 1'b1, 1'b1, 2'd0, 1'b0);
        step("pre_fire",      4'b0101, 1'b1, 1'b1, 2'd2, 1'b1);
        step("pre_pulse_end", 4'b0101, 1'b1, 1'b1, 2'd2, 1'b0);
        step("lone_g0",       4'b0001, 1'b1, 1'b1, 2'd0, 1'b0);
        for (int k = 0; k < 6; k++)
            step("lone_hold", 4'b0001, 1'b1, 1'b1, 2'd0, 1'b0);
        step("sat_pre",       4'b0101, 1'b1, 1'b1, 2'd2, 1'b1);
        step("idle3",         4'b0000, 1'b1, 1'b0, 2'd2, 1'b0);

        step("en_g1",         4'b0010, 1'b1, 1'b1, 2'd1, 1'b0);
        for (int k = 0; k < 6; k++)
            step("en_off_hold", 4'b1111, 1'b0, 1'b1, 2'd1, 1'b0);
        step("en_off_rel",    4'b1101, 1'b0, 1'b0, 2'd1, 1'b0);
        step("en_off_idle",   4'b1101, 1'b0, 1'b0, 2'd1, 1'b0);
        step("en_on_g2",      4'b1101, 1'b1, 1'b1, 2'd2, 1'b0);

        // Reset lands mid-cycle; the previous pointer (2) would pick 2, a cleared one picks 1
        req = 4'b1111;
        #2 rst_n = 1'b0;
        #1;
        expect_out(1'b0, 2'd0, 1'b0);
        check_out("async_reset");
        #2 rst_n = 1'b1;
        step("ptr_cleared",   4'b1110, 1'b1, 1'b1, 2'd1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
